// File: rtl/vga_sync_gen.sv
// Raster timing generator: position counters plus registered, mutually aligned sync/flag outputs.
// Optional frame counter enabled by defining VGA_SYNC_FRAME_COUNT_EN.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  HLast      = 10'(HTotal - 1);
  localparam logic [9:0]  VLast      = 10'(VTotal - 1);
  // 11-bit bounds so a sync pulse ending exactly at a total of 1024 still compares correctly
  localparam logic [10:0] HActive    = 11'(H_ACTIVE);
  localparam logic [10:0] VActive    = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VSyncEnd   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic       line_tick_q, line_tick_d, frame_tick_q, frame_tick_d;
  logic       h_wrap, v_wrap;

  // Outputs decode the next counter value so they describe the pixel loaded on the same edge
  always_comb begin
    h_wrap = (h_q == HLast);
    v_wrap = (v_q == VLast);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
    hsync_d = (({1'b0, h_d} >= HSyncStart) && ({1'b0, h_d} < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (({1'b0, v_d} >= VSyncStart) && ({1'b0, v_d} < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    video_on_d   = ({1'b0, h_d} < HActive) && ({1'b0, v_d} < VActive);
    line_tick_d  = (h_d == 10'd0);
    frame_tick_d = (h_d == 10'd0) && (v_d == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q          <= HLast;
      v_q          <= VLast;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      video_on_q   <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic [7:0] frame_count_q;
  logic       fresh_q;

  // fresh_q suppresses the increment on the first frame start after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= 8'd0;
      fresh_q       <= 1'b1;
    end else begin
      fresh_q <= 1'b0;
      if (frame_tick_d && !fresh_q) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 8'd0;
`endif

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign pixel_x    = h_q;
  assign pixel_y    = v_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a standard 640x480 instance and a tiny positive-polarity instance
// checked every cycle against an elapsed-time raster model.
module tb_vga_sync_gen;

  // Small instance geometry: 12 x 8 raster, 96 cycles per frame
  localparam int SHA = 6, SHF = 2, SHS = 2, SHB = 2;
  localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;
  localparam int SFRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

`ifdef VGA_SYNC_FRAME_COUNT_EN
  localparam bit FcEn = 1'b1;
`else
  localparam bit FcEn = 1'b0;
`endif

  typedef struct {
    int x, y, hs, vs, von, lt, ft, fc;
  } exp_t;

  typedef struct {
    exp_t s;  // standard instance
    exp_t m;  // small instance
  } pair_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hs_s, vs_s, von_s, lt_s, ft_s, hs_m, vs_m, von_m, lt_m, ft_m;
  logic [9:0] x_s, y_s, x_m, y_m;
  logic [7:0] fc_s, fc_m;

  pair_t q[$];
  int    t = 0;
  int    n_cmp = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_s (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hs_s),
    .vsync      (vs_s),
    .video_on   (von_s),
    .pixel_x    (x_s),
    .pixel_y    (y_s),
    .line_tick  (lt_s),
    .frame_tick (ft_s),
    .frame_count(fc_s)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .SYNC_POL(1'b1)
  ) dut_m (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hs_m),
    .vsync      (vs_m),
    .video_on   (von_m),
    .pixel_x    (x_m),
    .pixel_y    (y_m),
    .line_tick  (lt_m),
    .frame_tick (ft_m),
    .frame_count(fc_m)
  );

  // Expected raster state after 'el' non-reset edges since the last reset
  function automatic exp_t model(input int ha, hf, hsw, hb, va, vf, vsw, vb, input int pol,
                                 input bit rst, input int el);
    exp_t e;
    int ht, vt;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (rst) begin
      e.x = ht - 1; e.y = vt - 1; e.von = 0; e.hs = 1 - pol; e.vs = 1 - pol;
      e.lt = 0; e.ft = 0; e.fc = 0;
    end else begin
      e.x   = el % ht;
      e.y   = (el / ht) % vt;
      e.von = (e.x < ha && e.y < va) ? 1 : 0;
      e.hs  = (e.x >= ha + hf && e.x < ha + hf + hsw) ? pol : 1 - pol;
      e.vs  = (e.y >= va + vf && e.y < va + vf + vsw) ? pol : 1 - pol;
      e.lt  = (e.x == 0) ? 1 : 0;
      e.ft  = (e.x == 0 && e.y == 0) ? 1 : 0;
      e.fc  = FcEn ? (el / (ht * vt)) % 256 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  task automatic chk_inst(input string tag, input exp_t e, input int x, y, hs, vs, von, lt, ft,
                          input int fc);
    chk({tag, ".pixel_x"}, x, e.x);
    chk({tag, ".pixel_y"}, y, e.y);
    chk({tag, ".hsync"}, hs, e.hs);
    chk({tag, ".vsync"}, vs, e.vs);
    chk({tag, ".video_on"}, von, e.von);
    chk({tag, ".line_tick"}, lt, e.lt);
    chk({tag, ".frame_tick"}, ft, e.ft);
    chk({tag, ".frame_count"}, fc, e.fc);
  endtask

  // Drive one edge worth of reset and record what that edge must produce
  task automatic step(input bit r);
    pair_t p;
    @(negedge clk);
    reset = r;
    p.s = model(640, 16, 96, 48, 480, 10, 2, 33, 0, r, t);
    p.m = model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1, r, t);
    q.push_back(p);
    if (r) t = 0;
    else   t++;
  endtask

  // Monitor: every edge presents a new pixel, so pop and compare once per cycle
  initial begin
    pair_t p;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        p = q.pop_front();
        chk_inst("std", p.s, int'(x_s), int'(y_s), int'(hs_s), int'(vs_s), int'(von_s),
                 int'(lt_s), int'(ft_s), int'(fc_s));
        chk_inst("pol1", p.m, int'(x_m), int'(y_m), int'(hs_m), int'(vs_m), int'(von_m),
                 int'(lt_m), int'(ft_m), int'(fc_m));
      end
    end
  end

  initial begin
    repeat (3) step(1'b1);
    // Covers two full standard lines plus the small instance's frame and vsync wraps
    repeat (1700) step(1'b0);
    for (int i = 0; i < 6; i++) begin
      int run_len, rst_len;
      run_len = $urandom_range(1, 400);
      rst_len = $urandom_range(1, 3);
      repeat (run_len) step(1'b0);
      repeat (rst_len) step(1'b1);
    end
    // 257 small frames so the frame counter passes through 255 back to 0
    repeat (2) step(1'b1);
    repeat (257 * SFRAME + 40) step(1'b0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the game's 640x480@60 Hz VGA output. Runs on the 25 MHz pixel clock produced by the clock divider: one pixel per `clk` edge. Maintains horizontal and vertical position counters and produces registered hsync/vsync, the active-video flag, the current pixel coordinates, and line/frame strobes. The sprite/renderer stage consumes these outputs.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: hsync pulse width
- `H_BACK`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vsync pulse width
- `V_BACK`, 33: vertical back porch
- `SYNC_POL`, 0: active level of hsync/vsync (0 = active-low, per 640x480 standard)

Ports:
- `clk`  in  1  pixel clock, 25 MHz divided clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `hsync`  out  1  horizontal sync, registered
- `vsync`  out  1  vertical sync, registered
- `video_on`  out  1  high when (pixel_x, pixel_y) is inside the visible area
- `pixel_x`  out  10  current column, 0..H_TOTAL-1
- `pixel_y`  out  10  current line, 0..V_TOTAL-1
- `line_tick`  out  1  one-cycle pulse while pixel_x == 0
- `frame_tick`  out  1  one-cycle pulse while pixel_x == 0 and pixel_y == 0
- `frame_count`  out  8  frame counter (see Configuration)

## Operation
- H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Counters are 10 bits wide; parameters must keep totals ≤ 1024.
- Horizontal counter: increments every cycle; wraps to 0 after H_TOTAL-1.
- Vertical counter: increments only on the cycle where the horizontal counter wraps; wraps to 0 after V_TOTAL-1. A simultaneous horizontal and vertical wrap goes from (799,524) to (0,0) in one edge.
- hsync is active for pixel_x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] = [656,751]. Otherwise it is inactive.
- vsync is active for pixel_y in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] = [490,491]. Otherwise it is inactive.
- Active level is SYNC_POL; inactive level is ~SYNC_POL.
- video_on = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE).
- All outputs are registered and mutually aligned. On each edge they present the decode of the counter value loaded on that same edge, so they always describe the pixel currently being driven. Zero skew between coordinates and sync/flags.

## Timing
- Reset (sampled on posedge): counters load (H_TOTAL-1, V_TOTAL-1). Outputs on the same edge become:
  - pixel_x = 799, pixel_y = 524
  - video_on = 0, hsync = vsync = inactive
  - line_tick = frame_tick = 0, frame_count = 0
- First edge with reset low: outputs show (0,0) with video_on = 1, line_tick = 1, frame_tick = 1. There is no lost or partial first frame.
- Reset asserted mid-frame: takes effect on the next edge, same values as above. Counting resumes at (0,0) on the first edge after release.
- Line period is 800 cycles and frame period is 420000 cycles. line_tick is high 1 cycle in 800; frame_tick is high 1 cycle in 420000.
- hsync low for 96 consecutive cycles per line. vsync low for 2 full lines (1600 cycles), starting at pixel (0,490).

## Configuration
- `VGA_SYNC_FRAME_COUNT_EN` defined:
  - frame_count increments by 1 on every edge where frame_tick is asserted, wrapping 255 → 0.
  - It is reset to 0 and does not increment on the first frame_tick after reset; the first frame is frame 0.
  - Used by the game for animation timing.
- Undefined: frame_count is tied to 8'd0 and no counter register is built. All other behaviour is identical.

## Test plan
- Reset: hold reset 3 cycles → pixel_x=799, pixel_y=524, video_on=0, hsync=vsync=1, ticks=0. First edge after release → (0,0), video_on=1, line_tick=1, frame_tick=1.
- Horizontal sweep: step one line → video_on falls at pixel_x=640. hsync=0 exactly for pixel_x 656..751. Wrap 799→0 increments pixel_y by 1 with line_tick=1.
- Frame wrap: run to (799,524) → next edge (0,0) with frame_tick=1. vsync=0 exactly for pixel_y 490..491 (1600 cycles). frame_tick period measures 420000 cycles.
- Reset mid-frame at (300,200) → next edge shows reset values. Edge after release shows (0,0), frame_tick=1.
- SYNC_POL=1 instance: hsync high only for pixel_x 656..751; idle/reset level 0.
- With `VGA_SYNC_FRAME_COUNT_EN`: run 256 frames → frame_count 0,1,…,255, then 0 on the 257th frame_tick. Without the macro, frame_count stays 0 throughout.
